stall_or_merge: RTL and testbench

- Parametrised successor to the fixed 6-input hazard OR used to merge pipeline stall/flush requests.
- OR-reduces N_SRC request lines, each with a runtime mask, and produces two outputs:
  - a combinational merged request, drop-in compatible with the old block;
  - a registered stall with a programmable hold (pulse stretch).
- Latches the index of the source that started each stall episode.
- Sits between the hazard detection / branch units and the IF/ID pipeline-register enables.

---
 rtl/stall_or_merge_pkg.sv | 19 +
 rtl/stall_or_merge_prio_enc.sv | 25 ++
 rtl/stall_or_merge.sv | 133 +++++++++++++
 tb/tb_stall_or_merge.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/stall_or_merge_pkg.sv
// stall_or_pkg: shared constants, width helper and types for the stall/flush
// request merger (stall_or_merge) and its lowest-set-bit priority encoder.
package stall_or_pkg;

  // Default width of the hold-length input / hold counter.
  localparam int HOLD_W_DEF = 3;

  // Default number of request sources (matches the legacy 6-input OR).
  localparam int N_SRC_DEF = 6;

  // Index width needed to name one of n sources; never narrower than 1 bit.
  function automatic int src_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Cause index type for the default source count.
  typedef logic [src_idx_w(N_SRC_DEF)-1:0] cause_id_t;

endpackage

// File: rtl/stall_or_merge_prio_enc.sv
// prio_enc_lsb: combinational lowest-set-bit priority encoder.
// Ports:
//   in_i    [N]      request vector
//   idx_o   [IDX_W]  index of the lowest set bit (0 when none set)
//   valid_o          at least one bit of in_i is set
module prio_enc_lsb #(
  parameter int N     = 6,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     in_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  assign valid_o = |in_i;

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx_o = in_i[i] ? IDX_W'(i) : idx_o;
    end
  end

endmodule

// File: rtl/stall_or_merge.sv
// stall_or_merge: merges N_SRC maskable stall/flush request lines.
// any_comb is the zero-latency OR of the unmasked requests (drop-in for the
// old fixed OR); stall_q is a registered copy stretched by hold_len cycles
// after the last active request. cause_id latches the lowest active source
// at the start of each stall episode.
// Optional build macro: STALL_OR_STATS_EN enables the saturating episode
// counter ep_count (cleared by stat_clr); without it ep_count is tied to 0.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req        [N_SRC]    request lines (bit i = source i)
//   mask_we, mask_wdata   mask register write (1 = source disabled)
//   hold_len   [HOLD_W]   extra stall cycles after the last active request
//   any_comb              combinational |(req & ~mask_q)
//   stall_q               registered, stretched stall
//   hold_cnt   [HOLD_W]   current hold counter
//   cause_id              source index that opened the current/last episode
//   mask_q     [N_SRC]    current mask register
//   ep_count   [STAT_W]   saturating episode count
//   stat_clr              synchronous clear of ep_count
module stall_or_merge
  import stall_or_pkg::*;
#(
  parameter int               N_SRC    = 6,
  parameter int               HOLD_W   = HOLD_W_DEF,
  parameter logic [N_SRC-1:0] MASK_RST = '0,
  parameter int               STAT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_SRC-1:0]              req,
  input  logic                          mask_we,
  input  logic [N_SRC-1:0]              mask_wdata,
  input  logic [HOLD_W-1:0]             hold_len,
  output logic                          any_comb,
  output logic                          stall_q,
  output logic [HOLD_W-1:0]             hold_cnt,
  output logic [src_idx_w(N_SRC)-1:0]   cause_id,
  output logic [N_SRC-1:0]              mask_q,
  output logic [STAT_W-1:0]             ep_count,
  input  logic                          stat_clr
);

  localparam int IDX_W = src_idx_w(N_SRC);

  logic [N_SRC-1:0]  active_s;
  logic [IDX_W-1:0]  low_idx_s;
  logic              any_s;
  logic              start_s;
  logic              stall_d;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_d;
  logic [IDX_W-1:0]  cause_q;
  logic [IDX_W-1:0]  cause_d;

  // The mask register in effect this cycle gates requests; a write lands next cycle.
  assign active_s = req & ~mask_q;

  prio_enc_lsb #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_enc (
    .in_i    (active_s),
    .idx_o   (low_idx_s),
    .valid_o (any_s)
  );

  assign any_comb = any_s;
  // An episode opens on any active request while no stall is being driven.
  assign start_s  = any_s & ~stall_q;
  assign hold_cnt = hold_cnt_q;
  assign cause_id = cause_q;

  // Next-state: request reloads the hold, otherwise drain to zero without underflow.
  always_comb begin
    stall_d    = 1'b0;
    hold_cnt_d = hold_cnt_q;
    cause_d    = cause_q;
    if (any_s) begin
      stall_d    = 1'b1;
      hold_cnt_d = hold_len;
    end else if (hold_cnt_q != '0) begin
      stall_d    = 1'b1;
      hold_cnt_d = hold_cnt_q - HOLD_W'(1);
    end else begin
      stall_d    = 1'b0;
      hold_cnt_d = hold_cnt_q;
    end
    if (start_s) begin
      cause_d = low_idx_s;
    end else begin
      cause_d = cause_q;
    end
  end

  // Stall, hold counter, cause and mask registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q    <= 1'b0;
      hold_cnt_q <= '0;
      cause_q    <= '0;
      mask_q     <= MASK_RST;
    end else begin
      stall_q    <= stall_d;
      hold_cnt_q <= hold_cnt_d;
      cause_q    <= cause_d;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end
    end
  end

`ifdef STALL_OR_STATS_EN
  logic [STAT_W-1:0] ep_count_q;

  // Saturating episode counter; a clear beats a simultaneous episode start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ep_count_q <= '0;
    end else if (stat_clr) begin
      ep_count_q <= '0;
    end else if (start_s && (ep_count_q != {STAT_W{1'b1}})) begin
      ep_count_q <= ep_count_q + STAT_W'(1);
    end
  end

  assign ep_count = ep_count_q;
`else
  logic unused_stat_clr_s;
  assign unused_stat_clr_s = stat_clr;
  assign ep_count          = '0;
`endif

endmodule

// File: tb/tb_stall_or_merge.sv
module tb_stall_or_merge;
  import stall_or_pkg::*;

  localparam int N  = 6;
  localparam int HW = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic          mask_we = 1'b0;
  logic [N-1:0]  mask_wdata = '0;
  logic [HW-1:0] hold_len = '0;
  logic          any_comb;
  logic          stall_q;
  logic [HW-1:0] hold_cnt;
  cause_id_t     cause_id;
  logic [N-1:0]  mask_q;
  logic [SW-1:0] ep_count;
  logic          stat_clr = 1'b0;

  stall_or_merge #(
    .N_SRC    (N),
    .HOLD_W   (HW),
    .MASK_RST (6'h00),
    .STAT_W   (SW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .hold_len   (hold_len),
    .any_comb   (any_comb),
    .stall_q    (stall_q),
    .hold_cnt   (hold_cnt),
    .cause_id   (cause_id),
    .mask_q     (mask_q),
    .ep_count   (ep_count),
    .stat_clr   (stat_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] req;
    logic       mwe;
    logic [5:0] mwd;
    logic [2:0] hl;
    logic       e_any;
    logic       e_stall;
    logic [2:0] e_hold;
    logic [2:0] e_cause;
    logic [5:0] e_mask;
    logic [1:0] e_ep;
  } vec_t;

  typedef struct {
    logic       stall;
    logic [2:0] hold;
    logic [2:0] cause;
    logic [5:0] mask;
    logic [1:0] ep;
    int         row;
  } exp_t;

  vec_t vt[$];
  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Expected episode count: real value with the stats build, else always zero.
  function automatic logic [1:0] ep_exp(input logic [1:0] v);
`ifdef STALL_OR_STATS_EN
    return v;
`else
    return 2'd0 & v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] r, input logic we, input logic [5:0] wd, input logic [2:0] hl,
                     input logic a, input logic s, input logic [2:0] h, input logic [2:0] c,
                     input logic [5:0] m, input logic [1:0] e);
    vec_t v;
    v.req = r; v.mwe = we; v.mwd = wd; v.hl = hl;
    v.e_any = a; v.e_stall = s; v.e_hold = h; v.e_cause = c; v.e_mask = m; v.e_ep = e;
    vt.push_back(v);
  endtask

  // Drive one table row at the falling edge, check any_comb, queue post-edge expectations.
  task automatic apply(input vec_t v, input int row);
    exp_t e;
    exp_t g;
    @(negedge clk);
    req = v.req; mask_we = v.mwe; mask_wdata = v.mwd; hold_len = v.hl; stat_clr = 1'b0;
    #1;
    chk($sformatf("r%0d any_comb", row), 32'(any_comb), 32'(v.e_any));
    e.stall = v.e_stall; e.hold = v.e_hold; e.cause = v.e_cause;
    e.mask = v.e_mask; e.ep = ep_exp(v.e_ep); e.row = row;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    chk($sformatf("r%0d stall_q", g.row),  32'(stall_q),  32'(g.stall));
    chk($sformatf("r%0d hold_cnt", g.row), 32'(hold_cnt), 32'(g.hold));
    chk($sformatf("r%0d cause_id", g.row), 32'(cause_id), 32'(g.cause));
    chk($sformatf("r%0d mask_q", g.row),   32'(mask_q),   32'(g.mask));
    chk($sformatf("r%0d ep_count", g.row), 32'(ep_count), 32'(g.ep));
  endtask

  // One plain cycle with optional stat_clr, no mask write.
  task automatic cyc(input logic [5:0] r, input logic [2:0] hl, input logic clr);
    @(negedge clk);
    req = r; mask_we = 1'b0; hold_len = hl; stat_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   req   we wd    hl | any st hold cause mask  ep
    add(6'h04, 0, 6'h00, 2,  1, 1, 2, 2, 6'h00, 1);  // single pulse, hold 2
    add(6'h00, 0, 6'h00, 2,  0, 1, 1, 2, 6'h00, 1);
    add(6'h00, 0, 6'h00, 2,  0, 1, 0, 2, 6'h00, 1);
    add(6'h00, 0, 6'h00, 2,  0, 0, 0, 2, 6'h00, 1);  // third stall cycle was the last
    add(6'h00, 0, 6'h00, 2,  0, 0, 0, 2, 6'h00, 1);  // cause holds when idle
    add(6'h02, 0, 6'h00, 3,  1, 1, 3, 1, 6'h00, 2);  // retrigger test, source 1
    add(6'h00, 0, 6'h00, 3,  0, 1, 2, 1, 6'h00, 2);
    add(6'h10, 0, 6'h00, 3,  1, 1, 3, 1, 6'h00, 2);  // source 4 reloads, cause stays 1
    add(6'h00, 0, 6'h00, 7,  0, 1, 2, 1, 6'h00, 2);  // hold_len change ignored mid-hold
    add(6'h00, 0, 6'h00, 7,  0, 1, 1, 1, 6'h00, 2);
    add(6'h00, 0, 6'h00, 3,  0, 1, 0, 1, 6'h00, 2);
    add(6'h00, 0, 6'h00, 3,  0, 0, 0, 1, 6'h00, 2);
    add(6'h08, 0, 6'h00, 0,  1, 1, 0, 3, 6'h00, 3);  // hold 0: pure one-cycle delay
    add(6'h00, 0, 6'h00, 0,  0, 0, 0, 3, 6'h00, 3);
    add(6'h20, 0, 6'h00, 0,  1, 1, 0, 5, 6'h00, 3);  // back-to-back new episode, ep saturates
    add(6'h20, 0, 6'h00, 1,  1, 1, 1, 5, 6'h00, 3);  // request while stalled: retrigger only
    add(6'h00, 0, 6'h00, 1,  0, 1, 0, 5, 6'h00, 3);
    add(6'h00, 0, 6'h00, 1,  0, 0, 0, 5, 6'h00, 3);
    add(6'h28, 0, 6'h00, 1,  1, 1, 1, 3, 6'h00, 3);  // simultaneous sources 3,5 -> 3
    add(6'h00, 0, 6'h00, 1,  0, 1, 0, 3, 6'h00, 3);
    add(6'h00, 0, 6'h00, 1,  0, 0, 0, 3, 6'h00, 3);
    add(6'h01, 1, 6'h01, 2,  1, 1, 2, 0, 6'h01, 3);  // old mask governs write cycle
    add(6'h01, 0, 6'h00, 2,  0, 1, 1, 0, 6'h01, 3);  // now masked
    add(6'h01, 0, 6'h00, 2,  0, 1, 0, 0, 6'h01, 3);
    add(6'h01, 0, 6'h00, 2,  0, 0, 0, 0, 6'h01, 3);
    add(6'h3F, 0, 6'h00, 2,  1, 1, 2, 1, 6'h01, 3);  // lowest unmasked source is 1
    add(6'h00, 1, 6'h3F, 2,  0, 1, 1, 1, 6'h3F, 3);  // mask all mid-hold
    add(6'h3F, 0, 6'h00, 2,  0, 1, 0, 1, 6'h3F, 3);  // hold drains despite req
    add(6'h3F, 0, 6'h00, 2,  0, 0, 0, 1, 6'h3F, 3);
    add(6'h3F, 1, 6'h00, 0,  0, 0, 0, 1, 6'h00, 3);  // unmask: old (all-masked) still applies
    add(6'h00, 0, 6'h00, 0,  0, 0, 0, 1, 6'h00, 3);

    // Reset held with all requests up.
    rst_n = 1'b0;
    req   = 6'h3F;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst any_comb", 32'(any_comb), 32'd1);
    chk("rst stall_q",  32'(stall_q),  32'd0);
    chk("rst hold_cnt", 32'(hold_cnt), 32'd0);
    chk("rst cause_id", 32'(cause_id), 32'd0);
    chk("rst mask_q",   32'(mask_q),   32'd0);
    chk("rst ep_count", 32'(ep_count), 32'd0);
    req   = 6'h00;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle stall_q", 32'(stall_q), 32'd0);

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i], i + 1);
    end

    // Clear wins over a simultaneous episode start.
    cyc(6'h04, 3'd0, 1'b1);
    chk("clr stall_q",  32'(stall_q),  32'd1);
    chk("clr cause_id", 32'(cause_id), 32'd2);
    chk("clr ep_count", 32'(ep_count), 32'd0);
    cyc(6'h00, 3'd0, 1'b0);
    cyc(6'h01, 3'd0, 1'b0);
    chk("post-clr ep_count", 32'(ep_count), 32'(ep_exp(2'd1)));

    // Reset mid-episode drops the stall asynchronously.
    cyc(6'h00, 3'd0, 1'b0);
    cyc(6'h02, 3'd7, 1'b0);
    chk("pre-rst stall_q",  32'(stall_q),  32'd1);
    chk("pre-rst hold_cnt", 32'(hold_cnt), 32'd7);
    @(negedge clk);
    req   = 6'h00;
    rst_n = 1'b0;
    #1;
    chk("async rst stall_q",  32'(stall_q),  32'd0);
    chk("async rst hold_cnt", 32'(hold_cnt), 32'd0);
    chk("async rst cause_id", 32'(cause_id), 32'd0);
    chk("async rst ep_count", 32'(ep_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("after rst stall_q", 32'(stall_q), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
